// File: rtl/tl45_operand_fetch_if.sv
// tl45_operand_fetch_if
//
// Purpose: groups the decode-side inputs, the forwarding / writeback ports
// and the buffered execute-side outputs of the TL45 operand-fetch stage.
//
// Signals:
//   i_pipe_stall / i_pipe_flush : downstream stall / flush requests
//   o_pipe_stall / o_pipe_flush : stall / flush relayed to decode
//   i_opcode .. i_pc            : decoded instruction fields from decode
//   i_of_reg / i_of_val         : execute-stage forward (reg 0 = none)
//   i_wb_reg / i_wb_val         : writeback write port (reg 0 = none)
//   o_opcode .. o_pc            : registered instruction buffer for execute
//
// Modports:
//   slave  : view used by the operand-fetch stage itself
//   master : view used by whoever drives the stage (surrounding pipeline / bench)
interface tl45_operand_fetch_if;
   logic        i_pipe_stall;
   logic        i_pipe_flush;
   logic        o_pipe_stall;
   logic        o_pipe_flush;

   logic [4:0]  i_opcode;
   logic [3:0]  i_dr;
   logic [3:0]  i_sr1;
   logic [3:0]  i_sr2;
   logic [31:0] i_imm;
   logic        i_use_imm;
   logic [3:0]  i_jmp_cond;
   logic [31:0] i_pc;

   logic [3:0]  i_of_reg;
   logic [31:0] i_of_val;
   logic [3:0]  i_wb_reg;
   logic [31:0] i_wb_val;

   logic [4:0]  o_opcode;
   logic [3:0]  o_dr;
   logic [3:0]  o_jmp_cond;
   logic [31:0] o_sr1_val;
   logic [31:0] o_sr2_val;
   logic [31:0] o_target_offset;
   logic [31:0] o_pc;

   modport slave (
      input  i_pipe_stall, i_pipe_flush,
      output o_pipe_stall, o_pipe_flush,
      input  i_opcode, i_dr, i_sr1, i_sr2, i_imm, i_use_imm, i_jmp_cond, i_pc,
      input  i_of_reg, i_of_val, i_wb_reg, i_wb_val,
      output o_opcode, o_dr, o_jmp_cond, o_sr1_val, o_sr2_val, o_target_offset, o_pc
   );

   modport master (
      output i_pipe_stall, i_pipe_flush,
      input  o_pipe_stall, o_pipe_flush,
      output i_opcode, i_dr, i_sr1, i_sr2, i_imm, i_use_imm, i_jmp_cond, i_pc,
      output i_of_reg, i_of_val, i_wb_reg, i_wb_val,
      input  o_opcode, o_dr, o_jmp_cond, o_sr1_val, o_sr2_val, o_target_offset, o_pc
   );
endinterface

// File: rtl/tl45_operand_fetch.sv
// tl45_operand_fetch
//
// Purpose: operand-fetch stage of the TL45 pipeline. Holds the 16-entry
// register file (r0 reads as zero), resolves both source operands through
// the execute-stage forward and (optionally) the writeback bypass, and
// registers a one-instruction buffer for the execute stage. Downstream
// stall/flush are honoured and relayed upstream.
//
// Ports:
//   i_clk   : clock
//   i_reset : synchronous, active-high reset (clears buffer and r1..r15)
//   bus     : tl45_operand_fetch_if.slave (pipeline control, instruction
//             fields, forward/writeback ports, buffered outputs)
//
// Configuration macro:
//   TL45_RF_BYPASS_EN : when defined, a writeback value targeting a source
//                       register is bypassed straight to the operand and no
//                       local stall is ever raised. When undefined, such a
//                       collision inserts a single-cycle stall + bubble so
//                       the instruction re-reads the freshly written array.
module tl45_operand_fetch (
   input  logic                 i_clk,
   input  logic                 i_reset,
   tl45_operand_fetch_if.slave  bus
);

   logic [31:0] rf_q [16];
   logic [31:0] rf_d [16];

   logic [4:0]  opcode_q, opcode_d;
   logic [3:0]  dr_q, dr_d;
   logic [3:0]  jmp_cond_q, jmp_cond_d;
   logic [31:0] sr1_val_q, sr1_val_d;
   logic [31:0] sr2_val_q, sr2_val_d;
   logic [31:0] target_offset_q, target_offset_d;
   logic [31:0] pc_q, pc_d;

   logic [31:0] sr1_res;
   logic [31:0] sr2_res;
   logic        hazard_stall;

   // Register file next state: reset clears everything, otherwise the
   // writeback port updates one entry. Entry 0 is pinned to zero.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         rf_d[i] = rf_q[i];
      end
      if (i_reset) begin
         for (int i = 0; i < 16; i++) begin
            rf_d[i] = 32'd0;
         end
      end else if (bus.i_wb_reg != 4'd0) begin
         rf_d[bus.i_wb_reg] = bus.i_wb_val;
      end
      rf_d[0] = 32'd0;
   end

   // Source 1 resolution. A nonzero index equal to i_of_reg implies
   // i_of_reg is nonzero, so no separate "forward valid" test is needed.
   always_comb begin
      sr1_res = rf_q[bus.i_sr1];
      if (bus.i_sr1 == 4'd0) begin
         sr1_res = 32'd0;
      end else if (bus.i_sr1 == bus.i_of_reg) begin
         sr1_res = bus.i_of_val;
`ifdef TL45_RF_BYPASS_EN
      end else if (bus.i_sr1 == bus.i_wb_reg) begin
         sr1_res = bus.i_wb_val;
`endif
      end
   end

   // Source 2 resolution; the immediate replaces the register operand
   // entirely when i_use_imm is set.
   always_comb begin
      sr2_res = rf_q[bus.i_sr2];
      if (bus.i_use_imm) begin
         sr2_res = bus.i_imm;
      end else if (bus.i_sr2 == 4'd0) begin
         sr2_res = 32'd0;
      end else if (bus.i_sr2 == bus.i_of_reg) begin
         sr2_res = bus.i_of_val;
`ifdef TL45_RF_BYPASS_EN
      end else if (bus.i_sr2 == bus.i_wb_reg) begin
         sr2_res = bus.i_wb_val;
`endif
      end
   end

`ifdef TL45_RF_BYPASS_EN
   assign hazard_stall = 1'b0;
`else
   logic stall_done_q, stall_done_d;
   logic sr1_hit;
   logic sr2_hit;

   // A writeback into a source register that the forward does not cover
   // would be missed by the array read this cycle. Stall once; stall_done
   // remembers that this instruction already paid its bubble so it is not
   // stalled again. Reset and flush discard the instruction, so they
   // suppress the stall and leave the relay following i_pipe_stall only.
   always_comb begin
      sr1_hit = (bus.i_wb_reg != 4'd0) && (bus.i_sr1 == bus.i_wb_reg) &&
                (bus.i_sr1 != bus.i_of_reg);
      sr2_hit = (bus.i_wb_reg != 4'd0) && !bus.i_use_imm &&
                (bus.i_sr2 == bus.i_wb_reg) && (bus.i_sr2 != bus.i_of_reg);
      hazard_stall = (sr1_hit || sr2_hit) && !stall_done_q &&
                     !i_reset && !bus.i_pipe_flush;
   end

   // stall_done is held across external stalls and cleared whenever the
   // buffer is loaded with a new instruction or discarded.
   always_comb begin
      stall_done_d = 1'b0;
      if (i_reset || bus.i_pipe_flush) begin
         stall_done_d = 1'b0;
      end else if (bus.i_pipe_stall) begin
         stall_done_d = stall_done_q;
      end else if (hazard_stall) begin
         stall_done_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      stall_done_q <= stall_done_d;
   end
`endif

   // Instruction buffer next state: reset/flush give a NOP bubble, an
   // external stall holds, a local hazard inserts a bubble, else load.
   always_comb begin
      opcode_d        = opcode_q;
      dr_d            = dr_q;
      jmp_cond_d      = jmp_cond_q;
      sr1_val_d       = sr1_val_q;
      sr2_val_d       = sr2_val_q;
      target_offset_d = target_offset_q;
      pc_d            = pc_q;
      if (i_reset || bus.i_pipe_flush || (!bus.i_pipe_stall && hazard_stall)) begin
         opcode_d        = 5'd0;
         dr_d            = 4'd0;
         jmp_cond_d      = 4'd0;
         sr1_val_d       = 32'd0;
         sr2_val_d       = 32'd0;
         target_offset_d = 32'd0;
         pc_d            = 32'd0;
      end else if (!bus.i_pipe_stall) begin
         opcode_d        = bus.i_opcode;
         dr_d            = bus.i_dr;
         jmp_cond_d      = bus.i_jmp_cond;
         sr1_val_d       = sr1_res;
         sr2_val_d       = sr2_res;
         target_offset_d = bus.i_imm;
         pc_d            = bus.i_pc;
      end
   end

   // State registers; reset is folded into the _d logic above.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < 16; i++) begin
         rf_q[i] <= rf_d[i];
      end
      opcode_q        <= opcode_d;
      dr_q            <= dr_d;
      jmp_cond_q      <= jmp_cond_d;
      sr1_val_q       <= sr1_val_d;
      sr2_val_q       <= sr2_val_d;
      target_offset_q <= target_offset_d;
      pc_q            <= pc_d;
   end

   assign bus.o_pipe_stall    = bus.i_pipe_stall | hazard_stall;
   assign bus.o_pipe_flush    = bus.i_pipe_flush;
   assign bus.o_opcode        = opcode_q;
   assign bus.o_dr            = dr_q;
   assign bus.o_jmp_cond      = jmp_cond_q;
   assign bus.o_sr1_val       = sr1_val_q;
   assign bus.o_sr2_val       = sr2_val_q;
   assign bus.o_target_offset = target_offset_q;
   assign bus.o_pc            = pc_q;

endmodule

// File: tb/tb_tl45_operand_fetch.sv
// tb_tl45_operand_fetch
//
// Purpose: self-checking bench for tl45_operand_fetch. Directed steps walk
// through the register-file, forwarding, hazard, stall/flush and reset
// behaviour, then a randomized phase runs against a behavioural reference
// model of the stage kept here. Build with the same TL45_RF_BYPASS_EN
// setting as the design.
module tb_tl45_operand_fetch;

   typedef struct packed {
      logic [4:0]  opcode;
      logic [3:0]  dr;
      logic [3:0]  jmp_cond;
      logic [31:0] sr1_val;
      logic [31:0] sr2_val;
      logic [31:0] target_offset;
      logic [31:0] pc;
   } out_t;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   logic [31:0] m_rf [16];
   out_t        m_out;
   bit          m_stalled_once;

   tl45_operand_fetch_if bus ();

   tl45_operand_fetch dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it and reports a failure with tag/observed/expected.
   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Compares every buffered output against the model.
   task automatic checkOutput();
      checkVal("o_opcode",        {27'd0, bus.o_opcode},   {27'd0, m_out.opcode});
      checkVal("o_dr",            {28'd0, bus.o_dr},       {28'd0, m_out.dr});
      checkVal("o_jmp_cond",      {28'd0, bus.o_jmp_cond}, {28'd0, m_out.jmp_cond});
      checkVal("o_sr1_val",       bus.o_sr1_val,           m_out.sr1_val);
      checkVal("o_sr2_val",       bus.o_sr2_val,           m_out.sr2_val);
      checkVal("o_target_offset", bus.o_target_offset,     m_out.target_offset);
      checkVal("o_pc",            bus.o_pc,                m_out.pc);
   endtask

   // Operand value as seen by the stage: zero register, then execute forward,
   // then (bypass build only) the writeback value, then the array.
   function automatic logic [31:0] modelRead(input logic [3:0] s);
      if (s == 0) return 32'd0;
      if (s == bus.i_of_reg) return bus.i_of_val;
`ifdef TL45_RF_BYPASS_EN
      if (s == bus.i_wb_reg) return bus.i_wb_val;
`endif
      return m_rf[s];
   endfunction

   // Without bypass, a writeback into an uncovered source costs one bubble
   // per instruction; reset and flush discard the instruction instead.
   function automatic bit modelHazard();
`ifdef TL45_RF_BYPASS_EN
      return 1'b0;
`else
      bit conflict;
      conflict = 1'b0;
      if (bus.i_wb_reg != 0) begin
         if (bus.i_sr1 == bus.i_wb_reg && bus.i_sr1 != bus.i_of_reg) conflict = 1'b1;
         if (!bus.i_use_imm && bus.i_sr2 == bus.i_wb_reg && bus.i_sr2 != bus.i_of_reg) conflict = 1'b1;
      end
      return conflict && !m_stalled_once && !reset && !bus.i_pipe_flush;
`endif
   endfunction

   // Advances one cycle with the inputs currently driven: checks the
   // combinational relays, predicts the next buffer and array, clocks, and
   // checks the buffer after the edge.
   task automatic applyStimulus();
      out_t        nxt;
      bit          hz;
      bit          next_once;
      logic [31:0] rf_next [16];
      #1;
      hz = modelHazard();
      checkVal("o_pipe_stall", {31'd0, bus.o_pipe_stall}, {31'd0, bus.i_pipe_stall | hz});
      checkVal("o_pipe_flush", {31'd0, bus.o_pipe_flush}, {31'd0, bus.i_pipe_flush});

      nxt       = m_out;
      next_once = m_stalled_once;
      if (reset || bus.i_pipe_flush) begin
         nxt       = '0;
         next_once = 1'b0;
      end else if (bus.i_pipe_stall) begin
         nxt = m_out;
      end else if (hz) begin
         nxt       = '0;
         next_once = 1'b1;
      end else begin
         nxt.opcode        = bus.i_opcode;
         nxt.dr            = bus.i_dr;
         nxt.jmp_cond      = bus.i_jmp_cond;
         nxt.sr1_val       = modelRead(bus.i_sr1);
         nxt.sr2_val       = bus.i_use_imm ? bus.i_imm : modelRead(bus.i_sr2);
         nxt.target_offset = bus.i_imm;
         nxt.pc            = bus.i_pc;
         next_once         = 1'b0;
      end

      for (int i = 0; i < 16; i++) rf_next[i] = reset ? 32'd0 : m_rf[i];
      if (!reset && bus.i_wb_reg != 0) rf_next[bus.i_wb_reg] = bus.i_wb_val;

      @(posedge clk);
      m_out          = nxt;
      m_stalled_once = next_once;
      for (int i = 0; i < 16; i++) m_rf[i] = rf_next[i];
      #1;
      checkOutput();
   endtask

   task automatic setInstr(input logic [4:0] op, input logic [3:0] dr,
                           input logic [3:0] s1, input logic [3:0] s2,
                           input logic [31:0] imm, input logic use_imm,
                           input logic [3:0] jc, input logic [31:0] pc);
      bus.i_opcode   = op;
      bus.i_dr       = dr;
      bus.i_sr1      = s1;
      bus.i_sr2      = s2;
      bus.i_imm      = imm;
      bus.i_use_imm  = use_imm;
      bus.i_jmp_cond = jc;
      bus.i_pc       = pc;
   endtask

   task automatic setPorts(input logic [3:0] of_reg, input logic [31:0] of_val,
                           input logic [3:0] wb_reg, input logic [31:0] wb_val);
      bus.i_of_reg = of_reg;
      bus.i_of_val = of_val;
      bus.i_wb_reg = wb_reg;
      bus.i_wb_val = wb_val;
   endtask

   // Directed sequence followed by randomized traffic.
   initial begin
      total = 0;
      bad   = 0;
      m_stalled_once = 1'b0;
      m_out = '0;
      for (int i = 0; i < 16; i++) m_rf[i] = 32'd0;

      reset            = 1'b1;
      bus.i_pipe_stall = 1'b0;
      bus.i_pipe_flush = 1'b0;
      setInstr(5'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      setPorts(4'd0, 32'd0, 4'd0, 32'd0);
      @(posedge clk);
      #1;

      // Reset: outputs cleared, stall relay follows i_pipe_stall.
      applyStimulus();
      applyStimulus();
      reset = 1'b0;
      checkVal("reset_opcode", {27'd0, bus.o_opcode}, 32'd0);
      bus.i_pipe_stall = 1'b1;
      #1;
      checkVal("reset_stall_relay", {31'd0, bus.o_pipe_stall}, 32'd1);
      bus.i_pipe_stall = 1'b0;

      // Writeback r3, then ADD dr=1 sr1=3 sr2=0.
      setPorts(4'd0, 32'd0, 4'd3, 32'h1234_5678);
      applyStimulus();
      setPorts(4'd0, 32'd0, 4'd0, 32'd0);
      setInstr(5'd1, 4'd1, 4'd3, 4'd0, 32'd0, 1'b0, 4'd0, 32'h0000_0100);
      applyStimulus();
      checkVal("add_sr1", bus.o_sr1_val, 32'h1234_5678);
      checkVal("add_sr2", bus.o_sr2_val, 32'd0);
      checkVal("add_dr",  {28'd0, bus.o_dr}, 32'd1);

      // r5 = 7 in the array; execute forward of r5 overrides it, also
      // against a same-cycle writeback to r5.
      setInstr(5'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      setPorts(4'd0, 32'd0, 4'd5, 32'd7);
      applyStimulus();
      setInstr(5'd2, 4'd2, 4'd5, 4'd0, 32'd0, 1'b0, 4'd0, 32'h0000_0104);
      setPorts(4'd5, 32'hAAAA_0000, 4'd0, 32'd0);
      applyStimulus();
      checkVal("fwd_of", bus.o_sr1_val, 32'hAAAA_0000);
      setPorts(4'd5, 32'hAAAA_0000, 4'd5, 32'h0000_0999);
      applyStimulus();
      checkVal("fwd_of_over_wb", bus.o_sr1_val, 32'hAAAA_0000);

      // Same-cycle writeback r4 = 0x55 with a read of sr2 = 4.
      setInstr(5'd3, 4'd6, 4'd0, 4'd4, 32'd0, 1'b0, 4'd0, 32'h0000_0108);
      setPorts(4'd0, 32'd0, 4'd4, 32'h55);
`ifdef TL45_RF_BYPASS_EN
      applyStimulus();
      checkVal("bypass_sr2", bus.o_sr2_val, 32'h55);
`else
      applyStimulus();
      checkVal("hazard_bubble_op",  {27'd0, bus.o_opcode}, 32'd0);
      checkVal("hazard_bubble_sr2", bus.o_sr2_val, 32'd0);
      setPorts(4'd0, 32'd0, 4'd0, 32'd0);
      applyStimulus();
      checkVal("hazard_reread_sr2", bus.o_sr2_val, 32'h55);
      checkVal("hazard_reread_op",  {27'd0, bus.o_opcode}, 32'd3);
`endif

      // Writeback to r0 is ignored; r0 reads 0. Immediate replaces sr2.
      setInstr(5'd0, 4'd0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
      setPorts(4'd0, 32'd0, 4'd0, 32'hFFFF_FFFF);
      applyStimulus();
      setPorts(4'd0, 32'd0, 4'd0, 32'd0);
      setInstr(5'd4, 4'd7, 4'd0, 4'd9, 32'hFFFF_FFF0, 1'b1, 4'd2, 32'h0000_010C);
      applyStimulus();
      checkVal("r0_reads_zero", bus.o_sr1_val, 32'd0);
      checkVal("imm_sr2",       bus.o_sr2_val, 32'hFFFF_FFF0);
      checkVal("imm_target",    bus.o_target_offset, 32'hFFFF_FFF0);

      // Three stalled cycles with changing inputs: buffer holds.
      bus.i_pipe_stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         setInstr(5'(k + 8), 4'(k + 1), 4'(k + 3), 4'(k + 5), 32'(k * 17),
                  1'b0, 4'(k), 32'h2000 + 32'(k));
         applyStimulus();
      end
      checkVal("stall_hold_pc",  bus.o_pc, 32'h0000_010C);
      checkVal("stall_hold_imm", bus.o_sr2_val, 32'hFFFF_FFF0);

      // Flush and stall together: flush wins.
      bus.i_pipe_flush = 1'b1;
      #1;
      checkVal("flush_relay", {31'd0, bus.o_pipe_flush}, 32'd1);
      applyStimulus();
      checkVal("flush_clear_op", {27'd0, bus.o_opcode}, 32'd0);
      bus.i_pipe_flush = 1'b0;
      bus.i_pipe_stall = 1'b0;

      // Load an instruction, then reset during a held stall.
      setInstr(5'd5, 4'd8, 4'd3, 4'd4, 32'h10, 1'b0, 4'd1, 32'h0000_0200);
      applyStimulus();
      bus.i_pipe_stall = 1'b1;
      applyStimulus();
      reset = 1'b1;
      applyStimulus();
      checkVal("reset_in_stall_op", {27'd0, bus.o_opcode}, 32'd0);
      reset = 1'b0;
      bus.i_pipe_stall = 1'b0;
      for (int r = 1; r < 16; r++) begin
         setInstr(5'd6, 4'd1, 4'(r), 4'(r), 32'd0, 1'b0, 4'd0, 32'h300 + 32'(r));
         applyStimulus();
         checkVal("rf_cleared", bus.o_sr1_val, 32'd0);
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 400; n++) begin
         reset            = ($urandom_range(0, 63) == 0);
         bus.i_pipe_flush = ($urandom_range(0, 15) == 0);
         bus.i_pipe_stall = ($urandom_range(0, 4) == 0);
         setInstr(5'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  $urandom, 1'($urandom_range(0, 3) == 0), 4'($urandom), $urandom);
         setPorts(4'($urandom_range(0, 15)), $urandom,
                  4'($urandom_range(0, 15)), $urandom);
         applyStimulus();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
